// File: rtl/tpiu_sync_tracker.sv
// TPIU frame synchroniser: hunts for full-sync words, locks after a run of them,
// strips syncs from the stream and tags each data word with its frame position.
module tpiu_sync_tracker #(
    parameter int FRAME_WORDS  = 4,
    parameter int LOCK_THRESH  = 2,
    parameter int LOSS_TIMEOUT = 1024
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        IN_VALID,
    input  logic [31:0] IN_DATA,
    output logic        OUT_VALID,
    output logic [31:0] OUT_DATA,
    output logic        OUT_SOF,
    output logic [3:0]  OUT_IDX,
    output logic        LOCKED,
    output logic        SYNC_PULSE,
    output logic        HALF_PULSE,
    output logic [15:0] SYNC_CNT
);

    localparam logic [1:0]  ST_HUNT    = 2'd0;
    localparam logic [1:0]  ST_CONFIRM = 2'd1;
    localparam logic [1:0]  ST_LOCKED  = 2'd2;
    localparam logic [31:0] FULL_SYNC  = 32'h7FFF_FFFF;
    localparam logic [31:0] HALF_SYNC  = 32'h7FFF_7FFF;
    localparam logic [3:0]  LAST_IDX   = 4'(FRAME_WORDS - 1);
    localparam logic [3:0]  THRESH     = 4'(LOCK_THRESH);
    localparam logic [31:0] TIMEOUT    = 32'(LOSS_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  lc_q, lc_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [31:0] idle_q, idle_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_sof_q, out_sof_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic        locked_q, locked_d;
    logic        sync_pulse_q, sync_pulse_d;
    logic        half_pulse_q, half_pulse_d;
    logic [15:0] sync_cnt_q, sync_cnt_d;

    logic is_full, is_half, is_data;

    assign is_full = IN_VALID && (IN_DATA == FULL_SYNC);
    assign is_half = IN_VALID && (IN_DATA == HALF_SYNC);
    assign is_data = IN_VALID && !is_full && !is_half;

    always_comb begin
        state_d      = state_q;
        lc_d         = lc_q;
        ptr_d        = ptr_q;
        idle_d       = idle_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        out_idx_d    = out_idx_q;
        sync_pulse_d = is_full;
        half_pulse_d = is_half;
        sync_cnt_d   = sync_cnt_q;

        if (is_full && (sync_cnt_q != 16'hFFFF)) begin
            sync_cnt_d = sync_cnt_q + 16'd1;
        end

        case (state_q)
            ST_HUNT: begin
                if (is_full) begin
                    lc_d = 4'd1;
                    if (LOCK_THRESH == 1) begin
                        state_d = ST_LOCKED;
                        ptr_d   = 4'd0;
                        idle_d  = 32'd0;
                    end else begin
                        state_d = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                // Half syncs are padding between frames, so they neither advance nor break the run.
                if (is_full) begin
                    lc_d = lc_q + 4'd1;
                    if ((lc_q + 4'd1) == THRESH) begin
                        state_d = ST_LOCKED;
                        ptr_d   = 4'd0;
                        idle_d  = 32'd0;
                    end
                end else if (is_data) begin
                    lc_d    = 4'd0;
                    state_d = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (is_full) begin
                    ptr_d  = 4'd0;
                    idle_d = 32'd0;
                end else if (is_data) begin
                    out_valid_d = 1'b1;
                    out_data_d  = IN_DATA;
                    out_idx_d   = ptr_q;
                    out_sof_d   = (ptr_q == 4'd0);
                    ptr_d       = (ptr_q == LAST_IDX) ? 4'd0 : ptr_q + 4'd1;
                    idle_d      = idle_q + 32'd1;
                    // The word that hits the timeout is still delivered; lock drops with it.
                    if ((LOSS_TIMEOUT != 0) && ((idle_q + 32'd1) == TIMEOUT)) begin
                        state_d = ST_HUNT;
                        lc_d    = 4'd0;
                        idle_d  = 32'd0;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
                lc_d    = 4'd0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_HUNT;
            lc_q         <= 4'd0;
            ptr_q        <= 4'd0;
            idle_q       <= 32'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'd0;
            out_sof_q    <= 1'b0;
            out_idx_q    <= 4'd0;
            locked_q     <= 1'b0;
            sync_pulse_q <= 1'b0;
            half_pulse_q <= 1'b0;
            sync_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            lc_q         <= lc_d;
            ptr_q        <= ptr_d;
            idle_q       <= idle_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_idx_q    <= out_idx_d;
            locked_q     <= locked_d;
            sync_pulse_q <= sync_pulse_d;
            half_pulse_q <= half_pulse_d;
            sync_cnt_q   <= sync_cnt_d;
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign OUT_DATA   = out_data_q;
    assign OUT_SOF    = out_sof_q;
    assign OUT_IDX    = out_idx_q;
    assign LOCKED     = locked_q;
    assign SYNC_PULSE = sync_pulse_q;
    assign HALF_PULSE = half_pulse_q;
    assign SYNC_CNT   = sync_cnt_q;

endmodule

// File: tb/tb_tpiu_sync_tracker.sv
// Bench for tpiu_sync_tracker: a stream-level reference model checked every cycle,
// plus directed word sequences with literal expectations.
module tb_tpiu_sync_tracker;

    localparam int FW  = 4;
    localparam int TH  = 2;
    localparam int TO  = 8;
    localparam logic [31:0] FULL = 32'h7FFF_FFFF;
    localparam logic [31:0] HALF = 32'h7FFF_7FFF;

    logic        ACLK;
    logic        ARESET;
    logic        IN_VALID;
    logic [31:0] IN_DATA;
    logic        OUT_VALID;
    logic [31:0] OUT_DATA;
    logic        OUT_SOF;
    logic [3:0]  OUT_IDX;
    logic        LOCKED;
    logic        SYNC_PULSE;
    logic        HALF_PULSE;
    logic [15:0] SYNC_CNT;

    int assertCount = 0;
    int failCount   = 0;

    tpiu_sync_tracker #(
        .FRAME_WORDS(FW),
        .LOCK_THRESH(TH),
        .LOSS_TIMEOUT(TO)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .IN_VALID(IN_VALID),
        .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_DATA(OUT_DATA),
        .OUT_SOF(OUT_SOF),
        .OUT_IDX(OUT_IDX),
        .LOCKED(LOCKED),
        .SYNC_PULSE(SYNC_PULSE),
        .HALF_PULSE(HALF_PULSE),
        .SYNC_CNT(SYNC_CNT)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Reference model: "syncRun" counts consecutive full syncs while unlocked,
    // "sinceSync" counts data words delivered since the last full sync.
    int          syncRun;
    int          framePos;
    int          sinceSync;
    bit          mLocked;
    logic        mValid;
    logic [31:0] mData;
    logic [3:0]  mIdx;
    logic        mSof;
    logic        mSp;
    logic        mHp;
    logic [15:0] mCnt;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            syncRun = 0; framePos = 0; sinceSync = 0; mLocked = 0;
            mValid = 0; mData = 0; mIdx = 0; mSof = 0; mSp = 0; mHp = 0; mCnt = 0;
        end else begin
            mValid = 0; mSof = 0; mSp = 0; mHp = 0;
            if (IN_VALID) begin
                if (IN_DATA == FULL) begin
                    mSp = 1;
                    if (mCnt != 16'hFFFF) mCnt = mCnt + 1;
                end
                if (IN_DATA == HALF) mHp = 1;
                if (mLocked) begin
                    if (IN_DATA == FULL) begin
                        framePos = 0;
                        sinceSync = 0;
                    end else if (IN_DATA != HALF) begin
                        mValid = 1;
                        mData = IN_DATA;
                        mIdx = 4'(framePos);
                        mSof = (framePos == 0);
                        framePos = (framePos + 1) % FW;
                        sinceSync++;
                        if (TO != 0 && sinceSync == TO) begin
                            mLocked = 0;
                            syncRun = 0;
                        end
                    end
                end else begin
                    if (IN_DATA == FULL) begin
                        syncRun++;
                        if (syncRun >= TH) begin
                            mLocked = 1;
                            framePos = 0;
                            sinceSync = 0;
                        end
                    end else if (IN_DATA != HALF) begin
                        syncRun = 0;
                    end
                end
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge ACLK) begin
        checkVal("model OUT_VALID", 32'(OUT_VALID), 32'(mValid));
        checkVal("model OUT_DATA", OUT_DATA, mData);
        checkVal("model OUT_IDX", 32'(OUT_IDX), 32'(mIdx));
        checkVal("model OUT_SOF", 32'(OUT_SOF), 32'(mSof));
        checkVal("model LOCKED", 32'(LOCKED), 32'(mLocked));
        checkVal("model SYNC_PULSE", 32'(SYNC_PULSE), 32'(mSp));
        checkVal("model HALF_PULSE", 32'(HALF_PULSE), 32'(mHp));
        checkVal("model SYNC_CNT", 32'(SYNC_CNT), 32'(mCnt));
    end

    // Presents one word for exactly one edge; returns 2 time units after that edge.
    task automatic applyStimulus(input logic [31:0] w, input logic v);
        IN_VALID = v;
        IN_DATA  = w;
        @(posedge ACLK);
        #2;
        IN_VALID = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [31:0] d,
                               input logic [3:0] idx, input logic sof, input logic lk);
        #1;
        checkVal({name, " valid"}, 32'(OUT_VALID), 32'(v));
        if (v) begin
            checkVal({name, " data"}, OUT_DATA, d);
            checkVal({name, " idx"}, 32'(OUT_IDX), 32'(idx));
        end
        checkVal({name, " sof"}, 32'(OUT_SOF), 32'(sof));
        checkVal({name, " locked"}, 32'(LOCKED), 32'(lk));
    endtask

    initial begin
        logic [31:0] w;
        ARESET   = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = 32'd0;
        repeat (2) @(posedge ACLK);
        #2;
        checkOutput("reset", 0, 0, 0, 0, 0);
        checkVal("reset cnt", 32'(SYNC_CNT), 32'd0);
        ARESET = 1'b0;

        // Lock on two syncs, then one full frame plus the start of the next
        applyStimulus(FULL, 1);  checkOutput("lock s1", 0, 0, 0, 0, 0);
        applyStimulus(FULL, 1);  checkOutput("lock s2", 0, 0, 0, 0, 1);
        checkVal("lock s2 pulse", 32'(SYNC_PULSE), 32'd1);
        checkVal("lock s2 cnt", 32'(SYNC_CNT), 32'd2);
        for (int i = 0; i < 4; i++) begin
            w = 32'h1111_1111 * (i + 1);
            applyStimulus(w, 1);
            checkOutput("frame0", 1, w, 4'(i), (i == 0), 1);
        end
        applyStimulus(32'h5555_5555, 1); checkOutput("frame1 w0", 1, 32'h5555_5555, 0, 1, 1);

        // A full sync mid-frame realigns the pointer
        applyStimulus(FULL, 1);          checkOutput("realign s", 0, 0, 0, 0, 1);
        applyStimulus(32'h0000_000A, 1); checkOutput("realign A", 1, 32'h0000_000A, 0, 1, 1);
        applyStimulus(32'h0000_000B, 1); checkOutput("realign B", 1, 32'h0000_000B, 1, 0, 1);
        applyStimulus(FULL, 1);          checkOutput("realign s2", 0, 0, 0, 0, 1);
        checkVal("realign pulse", 32'(SYNC_PULSE), 32'd1);
        applyStimulus(32'h0000_000C, 1); checkOutput("realign C", 1, 32'h0000_000C, 0, 1, 1);
        checkVal("realign pulse end", 32'(SYNC_PULSE), 32'd0);
        applyStimulus(32'h0, 0);         checkOutput("idle hold", 0, 0, 0, 0, 1);
        checkVal("idle hold data", OUT_DATA, 32'h0000_000C);

        // Half sync is stripped without moving the pointer
        applyStimulus(FULL, 1);          checkOutput("half s", 0, 0, 0, 0, 1);
        applyStimulus(32'h0000_00A1, 1); checkOutput("half A", 1, 32'h0000_00A1, 0, 1, 1);
        applyStimulus(HALF, 1);          checkOutput("half h", 0, 0, 0, 0, 1);
        checkVal("half pulse", 32'(HALF_PULSE), 32'd1);
        applyStimulus(32'h0000_00B1, 1); checkOutput("half B", 1, 32'h0000_00B1, 1, 0, 1);
        checkVal("half pulse end", 32'(HALF_PULSE), 32'd0);

        // Loss timeout after 8 data words without a sync
        applyStimulus(FULL, 1);          checkOutput("to s", 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            w = 32'hA000_0000 + i;
            applyStimulus(w, 1);
            checkOutput("timeout", 1, w, 4'(i % 4), (i % 4 == 0), (i < 7));
        end
        applyStimulus(32'hA000_0008, 1); checkOutput("to 9th", 0, 0, 0, 0, 0);

        // A data word between syncs restarts the hunt
        applyStimulus(FULL, 1);          checkOutput("hunt s1", 0, 0, 0, 0, 0);
        applyStimulus(32'hDEAD_BEEF, 1); checkOutput("hunt dead", 0, 0, 0, 0, 0);
        applyStimulus(FULL, 1);          checkOutput("hunt s2", 0, 0, 0, 0, 0);
        applyStimulus(FULL, 1);          checkOutput("hunt s3", 0, 0, 0, 0, 1);
        applyStimulus(32'h1234_5678, 1); checkOutput("hunt d", 1, 32'h1234_5678, 0, 1, 1);
        applyStimulus(32'h0BAD_F00D, 1); checkOutput("pre-rst d", 1, 32'h0BAD_F00D, 1, 0, 1);

        // Asynchronous reset between edges, then relock from scratch
        ARESET = 1'b1;
        checkOutput("async rst", 0, 0, 0, 0, 0);
        checkVal("async rst cnt", 32'(SYNC_CNT), 32'd0);
        checkVal("async rst idx", 32'(OUT_IDX), 32'd0);
        @(posedge ACLK);
        #2;
        ARESET = 1'b0;
        applyStimulus(FULL, 1);          checkOutput("relock s1", 0, 0, 0, 0, 0);
        applyStimulus(32'h0000_0077, 1); checkOutput("relock d", 0, 0, 0, 0, 0);
        applyStimulus(FULL, 1);          checkOutput("relock s2", 0, 0, 0, 0, 0);
        applyStimulus(FULL, 1);          checkOutput("relock s3", 0, 0, 0, 0, 1);
        checkVal("relock cnt", 32'(SYNC_CNT), 32'd3);
        applyStimulus(32'h0000_0088, 1); checkOutput("relock d2", 1, 32'h0000_0088, 0, 1, 1);

        // Saturate the sync counter
        for (int i = 0; i < 65600; i++) applyStimulus(FULL, 1);
        #1;
        checkVal("sat cnt", 32'(SYNC_CNT), 32'h0000_FFFF);
        applyStimulus(32'h0, 0);
        checkOutput("sat idle", 0, 0, 0, 0, 1);
        checkVal("sat hold", 32'(SYNC_CNT), 32'h0000_FFFF);

        @(negedge ACLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
